// File: rtl/syscall_unit_pkg.sv
// syscall_unit_pkg: service codes, FSM states and ASCII constants shared by decode and the syscall engine.
package syscall_unit_pkg;
  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [7:0]  ASCII_0        = 8'h30;
  localparam logic [7:0]  ASCII_MINUS    = 8'h2D;
  typedef enum logic [2:0] {ST_IDLE, ST_CHAR, ST_INT, ST_STR_FETCH, ST_STR_EMIT, ST_DONE} state_t;
  function automatic logic [31:0] pow10(input logic [3:0] i);
    case (i)
      4'd9: return 32'd1000000000;
      4'd8: return 32'd100000000;
      4'd7: return 32'd10000000;
      4'd6: return 32'd1000000;
      4'd5: return 32'd100000;
      4'd4: return 32'd10000;
      4'd3: return 32'd1000;
      4'd2: return 32'd100;
      4'd1: return 32'd10;
      default: return 32'd1;
    endcase
  endfunction
endpackage

// File: rtl/syscall_unit_itoa.sv
// syscall_itoa: serialises a signed 32-bit value to ASCII decimal over valid/ready.
// One subtraction per cycle against descending powers of ten; leading zeros suppressed.
module syscall_itoa import syscall_unit_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_val,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  input  logic        i_ready
);
  logic        r_busy, r_neg, r_seen, r_valid, r_last;
  logic [31:0] r_mag;
  logic [3:0]  r_idx, r_digit;
  logic [7:0]  r_data;
  logic [31:0] w_pow;
  assign w_pow   = pow10(r_idx);
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_neg   <= 1'b0;
      r_seen  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_mag   <= '0;
      r_idx   <= '0;
      r_digit <= '0;
      r_data  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_neg   <= i_val[31];
      r_mag   <= i_val[31] ? -i_val : i_val;
      r_idx   <= 4'd9;
      r_digit <= '0;
      r_seen  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (r_valid) begin
      if (i_ready) begin
        r_valid <= 1'b0;
        if (r_last) r_busy <= 1'b0;
      end
    end else if (r_busy) begin
      if (r_neg) begin
        r_valid <= 1'b1;
        r_data  <= ASCII_MINUS;
        r_neg   <= 1'b0;
      end else if (r_mag >= w_pow) begin
        r_mag   <= r_mag - w_pow;
        r_digit <= r_digit + 4'd1;
      end else begin
        // units digit always prints so that zero yields "0"
        if (r_digit != 4'd0 || r_seen || r_idx == 4'd0) begin
          r_valid <= 1'b1;
          r_data  <= ASCII_0 + {4'b0, r_digit};
          r_seen  <= 1'b1;
          r_last  <= r_idx == 4'd0;
        end
        r_idx   <= r_idx - 4'd1;
        r_digit <= '0;
      end
    end
  end
endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: SYSCALL service engine (print int/string/char, exit) with console stream and memory read port.
// Stalls the pipeline while a service runs; halt is sticky until reset.
module syscall_unit import syscall_unit_pkg::*; #(
  parameter int MAX_STR = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall,
  input  logic [31:0]       v0,
  input  logic [31:0]       a0,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              halted
);
  localparam int CW = $clog2(MAX_STR + 1);
  state_t      r_state;
  logic [31:0] r_arg, r_word;
  logic [CW-1:0] r_cnt;
  logic        r_err, r_halted;
  logic        w_start, w_itoa_valid, w_itoa_last, w_str_cap;
  logic [7:0]  w_itoa_data, w_byte;
  assign w_start   = r_state == ST_IDLE && syscall && !r_halted && v0 == SYS_PRINT_INT;
  assign w_byte    = r_word[{r_arg[1:0], 3'b000} +: 8];
  assign w_str_cap = r_cnt == CW'(MAX_STR);
  assign char_valid = (r_state == ST_CHAR) || (r_state == ST_INT && w_itoa_valid) ||
                      (r_state == ST_STR_EMIT && w_byte != 8'd0 && !w_str_cap);
  assign char_data = !char_valid ? 8'd0 : r_state == ST_INT ? w_itoa_data :
                     r_state == ST_CHAR ? r_arg[7:0] : w_byte;
  assign busy      = (r_state != ST_IDLE && r_state != ST_DONE) || (r_state == ST_IDLE && syscall && !r_halted);
  assign done      = r_state == ST_DONE;
  assign err       = r_err;
  assign halted    = r_halted;
  assign mem_req   = r_state == ST_STR_FETCH;
  assign mem_addr  = ADDR_W'({r_arg[31:2], 2'b00});
  syscall_itoa u_itoa (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_val   (a0),
    .o_valid (w_itoa_valid),
    .o_data  (w_itoa_data),
    .o_last  (w_itoa_last),
    .i_ready (char_ready && r_state == ST_INT)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_arg    <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (syscall && !r_halted) begin
          r_arg <= a0;
          r_cnt <= '0;
          case (v0)
            SYS_PRINT_CHAR: r_state <= ST_CHAR;
            SYS_PRINT_INT:  r_state <= ST_INT;
            SYS_PRINT_STR:  r_state <= ST_STR_FETCH;
            SYS_EXIT: begin
              r_halted <= 1'b1;
              r_state  <= ST_DONE;
            end
            default: begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          endcase
        end
        ST_CHAR: if (char_ready) r_state <= ST_DONE;
        ST_INT: if (w_itoa_valid && char_ready && w_itoa_last) r_state <= ST_DONE;
        ST_STR_FETCH: if (mem_ack) begin
          r_word  <= mem_rdata;
          r_state <= ST_STR_EMIT;
        end
        ST_STR_EMIT: if (w_byte == 8'd0) r_state <= ST_DONE;
        else if (w_str_cap) begin
          r_err   <= 1'b1;
          r_state <= ST_DONE;
        end else if (char_ready) begin
          r_arg <= r_arg + 32'd1;
          r_cnt <= r_cnt + CW'(1);
          // last lane of the word consumed: fetch the next one
          if (r_arg[1:0] == 2'd3) r_state <= ST_STR_FETCH;
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
